// File: rtl/tlul_pkg.sv
// TL-UL payload types and opcodes shared by host and device sides.
package tlul_pkg;

  localparam int unsigned TlAddrW = 32;
  localparam int unsigned TlDataW = 32;
  localparam int unsigned TlMaskW = TlDataW / 8;
  localparam int unsigned TlSrcW  = 8;
  localparam int unsigned TlSzW   = 2;
  localparam int unsigned TlOpW   = 3;

  localparam logic [TlOpW-1:0] PutFullData    = 3'h0;
  localparam logic [TlOpW-1:0] PutPartialData = 3'h1;
  localparam logic [TlOpW-1:0] Get            = 3'h4;
  localparam logic [TlOpW-1:0] AccessAck      = 3'h0;
  localparam logic [TlOpW-1:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic               a_valid;
    logic [TlOpW-1:0]   a_opcode;
    logic [2:0]         a_param;
    logic [TlSzW-1:0]   a_size;
    logic [TlSrcW-1:0]  a_source;
    logic [TlAddrW-1:0] a_address;
    logic [TlMaskW-1:0] a_mask;
    logic [TlDataW-1:0] a_data;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic               d_valid;
    logic [TlOpW-1:0]   d_opcode;
    logic [2:0]         d_param;
    logic [TlSzW-1:0]   d_size;
    logic [TlSrcW-1:0]  d_source;
    logic [0:0]         d_sink;
    logic [TlDataW-1:0] d_data;
    logic               d_error;
    logic               a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_ram_dev.sv
// TL-UL word RAM device: Get/PutFull/PutPartial with an in-order response queue.
module student_tlul_ram_dev
  import tlul_pkg::*;
#(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned RespDepth = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW  = $clog2(RespDepth + 1);
  localparam logic [TlAddrW-1:0] ByteSpan = TlAddrW'(Depth * 4);

  typedef struct packed {
    logic [TlOpW-1:0]   opcode;
    logic [TlSzW-1:0]   size;
    logic [TlSrcW-1:0]  source;
    logic [TlDataW-1:0] data;
    logic               error;
  } rsp_t;

  logic [TlDataW-1:0] r_mem [Depth];
  rsp_t               r_q   [RespDepth];
  logic [PtrW-1:0]    r_wptr;
  logic [PtrW-1:0]    r_rptr;
  logic [CntW-1:0]    r_cnt;
  logic               r_a_ready;

  logic               w_is_get;
  logic               w_is_put;
  logic               w_err;
  logic               w_acc;
  logic               w_pop;
  logic [AddrW-1:0]   w_idx;
  logic [CntW-1:0]    w_cnt_nxt;
  rsp_t               w_rsp;
  logic               w_unused_param;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Request decode and response entry construction
  always_comb begin
    w_is_get  = (tl_i.a_opcode == Get);
    w_is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    w_err     = (tl_i.a_address >= ByteSpan) || (tl_i.a_address[1:0] != 2'b00) ||
                (tl_i.a_size != TlSzW'(2)) || !(w_is_get || w_is_put) ||
                ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF));
    w_idx     = tl_i.a_address[AddrW+1:2];
    w_acc     = tl_i.a_valid && r_a_ready && !rst_i;
    w_pop     = (r_cnt != '0) && tl_i.d_ready;
    w_cnt_nxt = r_cnt + CntW'(w_acc) - CntW'(w_pop);
    w_rsp        = '0;
    w_rsp.opcode = w_is_get ? AccessAckData : AccessAck;
    w_rsp.size   = tl_i.a_size;
    w_rsp.source = tl_i.a_source;
    w_rsp.error  = w_err;
    w_rsp.data   = (w_is_get && !w_err) ? r_mem[w_idx] : '0;
  end

  assign w_unused_param = ^tl_i.a_param;

  // Array contents survive reset; only accepted legal Puts modify them
  always_ff @(posedge clk_i) begin
    if (w_acc && w_is_put && !w_err) begin
      for (int k = 0; k < TlMaskW; k++) begin
        if (tl_i.a_mask[k]) begin
          r_mem[w_idx][8*k +: 8] <= tl_i.a_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_q[r_wptr] <= w_rsp;
    end
  end

  // a_ready is registered from the next count, so it never sees a_valid/d_ready combinationally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_a_ready <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_cnt     <= w_cnt_nxt;
      r_a_ready <= (w_cnt_nxt < CntW'(RespDepth));
    end
  end

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = r_a_ready;
    if (r_cnt != '0) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = r_q[r_rptr].opcode;
      tl_o.d_size   = r_q[r_rptr].size;
      tl_o.d_source = r_q[r_rptr].source;
      tl_o.d_data   = r_q[r_rptr].data;
      tl_o.d_error  = r_q[r_rptr].error;
    end
  end

endmodule
